// File: rtl/hdmi_rx_link_monitor_if.sv
// Link-side signal bundle of the HDMI RX link monitor.
// master: the monitor (consumes ready/lock status and drives the reset request and link status).
// slave:  the RX reset controller / transceiver side.
interface hdmi_rx_link_monitor_if;
  logic [2:0] rx_ready;
  logic [2:0] rx_is_lockedtodata;
  logic       rx_reset_req;
  logic       link_up;
  logic [2:0] channel_fail;
  logic [7:0] loss_count;
  logic       link_fault;

  modport master (
    input  rx_ready, rx_is_lockedtodata,
    output rx_reset_req, link_up, channel_fail, loss_count, link_fault
  );

  modport slave (
    output rx_ready, rx_is_lockedtodata,
    input  rx_reset_req, link_up, channel_fail, loss_count, link_fault
  );
endinterface

// File: rtl/hdmi_rx_link_monitor.sv
// HDMI RX link monitor: watches per-channel ready/CDR-lock and brings the link up
// only after a run of consecutive good cycles. It requests an RX reset on a timeout
// or a link loss, and keeps sticky loss statistics.
// Optional feature macro: LINK_MON_RETRY_LIMIT_EN. When it is defined, consecutive
// timeouts are counted and the block parks in FAULT after MAX_RETRIES attempts.
module hdmi_rx_link_monitor #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int RESET_PULSE    = 16,
  parameter int MAX_RETRIES    = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  hdmi_rx_link_monitor_if.master lnk
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int STB_W = (STABLE_CYCLES  > 1) ? $clog2(STABLE_CYCLES)  : 1;
  localparam int PLS_W = (RESET_PULSE    > 1) ? $clog2(RESET_PULSE)    : 1;
  localparam int RTY_W = (MAX_RETRIES    > 1) ? $clog2(MAX_RETRIES)    : 1;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
  localparam logic [PLS_W-1:0] PLS_LAST = PLS_W'(RESET_PULSE - 1);

  if (TIMEOUT_CYCLES < 1 || STABLE_CYCLES < 1 || RESET_PULSE < 1 || MAX_RETRIES < 1) begin : g_bad_cfg
    $error("hdmi_rx_link_monitor: all cycle/retry parameters must be >= 1");
  end

`ifdef LINK_MON_RETRY_LIMIT_EN
  typedef enum logic [2:0] {
    S_WAIT_READY, S_STABLE, S_LINK_UP, S_RESET_REQ, S_FAULT
  } state_t;
  // The retry counter only ever holds 0..MAX_RETRIES-1: the timeout that would reach
  // MAX_RETRIES goes straight to FAULT instead of being stored.
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);
  logic [RTY_W-1:0] rty_q, rty_d;
`else
  typedef enum logic [2:0] {
    S_WAIT_READY, S_STABLE, S_LINK_UP, S_RESET_REQ
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [STB_W-1:0] stb_q, stb_d;
  logic [PLS_W-1:0] pls_q, pls_d;
  logic [2:0]       cf_q, cf_d;
  logic [7:0]       lc_q, lc_d;
  logic             req_q, up_q, flt_q;

  logic [2:0] lock_p0, lock_p1;
  logic [2:0] good_bits;
  logic       good;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Two-flop synchronizer for the asynchronous CDR lock indications.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lock_p0 <= '0;
      lock_p1 <= '0;
    end else begin
      lock_p0 <= lnk.rx_is_lockedtodata;
      lock_p1 <= lock_p0;
    end
  end

  assign good_bits = lnk.rx_ready & lock_p1;
  assign good      = &good_bits;

  // Next-state and counter logic for the link bring-up / recovery FSM.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    stb_d   = stb_q;
    pls_d   = pls_q;
    cf_d    = cf_q;
    lc_d    = lc_q;
`ifdef LINK_MON_RETRY_LIMIT_EN
    rty_d   = rty_q;
`endif
    unique case (state_q)
      S_WAIT_READY: begin
        // The timer holds at its last value instead of wrapping.
        if (tmo_q != TMO_LAST) tmo_d = tmo_q + TMO_W'(1);
        if (good) begin
          state_d = S_STABLE;
          stb_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
`ifdef LINK_MON_RETRY_LIMIT_EN
          if (rty_q == RTY_LAST) begin
            state_d = S_FAULT;
          end else begin
            rty_d   = rty_q + RTY_W'(1);
            state_d = S_RESET_REQ;
            pls_d   = '0;
          end
`else
          state_d = S_RESET_REQ;
          pls_d   = '0;
`endif
        end
      end
      S_STABLE: begin
        // The timeout timer is deliberately kept so that a flapping link still times out.
        if (!good) begin
          state_d = S_WAIT_READY;
        end else if (stb_q == STB_LAST) begin
          state_d = S_LINK_UP;
`ifdef LINK_MON_RETRY_LIMIT_EN
          rty_d   = '0;
`endif
        end else begin
          stb_d = stb_q + STB_W'(1);
        end
      end
      S_LINK_UP: begin
        if (!good) begin
          cf_d    = cf_q | ~good_bits;
          lc_d    = sat_inc8(lc_q);
          state_d = S_RESET_REQ;
          pls_d   = '0;
`ifdef LINK_MON_RETRY_LIMIT_EN
          rty_d   = '0;
`endif
        end
      end
      S_RESET_REQ: begin
        if (pls_q == PLS_LAST) begin
          state_d = S_WAIT_READY;
          tmo_d   = '0;
          stb_d   = '0;
        end else begin
          pls_d = pls_q + PLS_W'(1);
        end
      end
`ifdef LINK_MON_RETRY_LIMIT_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_WAIT_READY;
    endcase
  end

  // State, counters and registered (Moore) outputs decoded from the next state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_WAIT_READY;
      tmo_q   <= '0;
      stb_q   <= '0;
      pls_q   <= '0;
      cf_q    <= '0;
      lc_q    <= '0;
      req_q   <= 1'b0;
      up_q    <= 1'b0;
      flt_q   <= 1'b0;
`ifdef LINK_MON_RETRY_LIMIT_EN
      rty_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      stb_q   <= stb_d;
      pls_q   <= pls_d;
      cf_q    <= cf_d;
      lc_q    <= lc_d;
      req_q   <= (state_d == S_RESET_REQ);
      up_q    <= (state_d == S_LINK_UP);
`ifdef LINK_MON_RETRY_LIMIT_EN
      flt_q   <= (state_d == S_FAULT);
      rty_q   <= rty_d;
`else
      flt_q   <= 1'b0;
`endif
    end
  end

  assign lnk.rx_reset_req = req_q;
  assign lnk.link_up      = up_q;
  assign lnk.channel_fail = cf_q;
  assign lnk.loss_count   = lc_q;
  assign lnk.link_fault   = flt_q;

endmodule

// File: doc/hdmi_rx_link_monitor.md
HDMI_RX_LINK_MONITOR -- requirements
Module: hdmi_rx_link_monitor

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum cycles in WAIT_READY before a reset retry.
REQ-002 SHALL have parameter STABLE_CYCLES, default 1024: consecutive all-good cycles required before link is declared up.
REQ-003 SHALL have parameter RESET_PULSE, default 16: width in cycles of rx_reset_req.
REQ-004 SHALL have parameter MAX_RETRIES, default 8: consecutive failed attempts before fault; used only with the macro in REQ-021.
REQ-005 SHALL have port clock, input, 1: single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port rx_ready, input, 3: per-channel ready from the RX reset controller; same clock domain.
REQ-008 SHALL have port rx_is_lockedtodata, input, 3: per-channel CDR lock from the transceiver; asynchronous.
REQ-009 SHALL have port rx_reset_req, output, 1: reset request to the RX reset controller reset input; active high.
REQ-010 SHALL have port link_up, output, 1: all 3 channels ready, locked and stable.
REQ-011 SHALL have port channel_fail, output, 3: sticky per-channel mask of channels whose drop caused a link loss.
REQ-012 SHALL have port loss_count, output, 8: saturating count of LINK_UP to RESET_REQ transitions.
REQ-013 SHALL have port link_fault, output, 1: retry limit exhausted.

Function
REQ-014 SHALL pass rx_is_lockedtodata through a 2-flop synchronizer; "good" = rx_ready & sync_locked, all 3 bits set.
REQ-015 SHALL implement the FSM WAIT_READY, STABLE, LINK_UP, RESET_REQ, FAULT.
- WAIT_READY: the timer increments each cycle.
- good, then STABLE with the counter cleared.
- Timer reaches TIMEOUT_CYCLES-1 without good, then RESET_REQ.
REQ-016 STABLE SHALL behave as follows.
- Counter increments while good.
- Any not-good cycle returns to WAIT_READY; the timeout timer is not cleared, so retries stay bounded.
- Counter reaches STABLE_CYCLES-1 with good, then LINK_UP.
REQ-017 LINK_UP SHALL behave as follows.
- link_up=1.
- First not-good cycle: OR the failing channels (~good bits) into channel_fail, increment loss_count (saturate at 255), clear the retry counter, then RESET_REQ.
REQ-018 RESET_REQ SHALL behave as follows.
- Drive rx_reset_req=1 for exactly RESET_PULSE cycles.
- Then go to WAIT_READY with the timers cleared.
- Input changes are ignored during the pulse.
REQ-019 SHALL register all outputs (Moore); link_up rises on the first cycle in LINK_UP and falls on the cycle after the drop is sampled.
REQ-020 SHALL size counters with $clog2 of the respective parameter, and SHALL NOT wrap any counter.

Configuration
REQ-021 With macro LINK_MON_RETRY_LIMIT_EN defined, the block SHALL count consecutive WAIT_READY timeouts.
- On reaching MAX_RETRIES, go to FAULT: link_fault=1, rx_reset_req=0, no exit except reset_n.
- The count clears on entry to LINK_UP.
REQ-022 With LINK_MON_RETRY_LIMIT_EN undefined, the block SHALL retry indefinitely, tie link_fault to 0, and omit FAULT and the retry counter.

Reset
REQ-023 On reset_n=0 at a clock edge, the block SHALL enter WAIT_READY and clear all counters and synchronizers.
- Outputs: rx_reset_req=0, link_up=0, channel_fail=0, loss_count=0, link_fault=0.
REQ-024 Reset asserted mid-pulse or in FAULT SHALL abort immediately; rx_reset_req is 0 on the next cycle.

Verification
(Params for all scenarios: TIMEOUT_CYCLES=100, STABLE_CYCLES=8, RESET_PULSE=4, MAX_RETRIES=3.)
REQ-025 Clean bring-up: rx_ready=3'b111, locked=3'b111 from cycle 0 after reset. Required: link_up=1 exactly 2+8+1 cycles later; rx_reset_req never asserted.
REQ-026 Glitch in STABLE: locked[1] low for 1 cycle at STABLE count 5. Required: return to WAIT_READY, link_up delayed by a full 8 good cycles, no rx_reset_req.
REQ-027 Link loss: in LINK_UP, drop rx_ready[2]. Required: link_up=0, channel_fail=3'b100, loss_count=1, rx_reset_req high 4 cycles.
REQ-028 Timeout, macro defined: rx_ready held 0. Required: rx_reset_req 4-cycle pulses every ~104 cycles; after the 3rd timeout link_fault=1 and pulses stop. Macro undefined: pulses continue and link_fault stays 0.
REQ-029 Saturation and reset: force 260 link losses. Required: loss_count stays 255. Then assert reset_n=0 during a rx_reset_req pulse. Required: all outputs 0 on the next cycle.
